// File: rtl/shared_adder_sched_pkg.sv
// Shared types and widths for the round-robin adder scheduler.
// Holds operand/slice widths, the stage-1 pipeline record and the response record.
// Imported by the interface, the arbiter and the top.
package shared_adder_sched_pkg;

  localparam int WIDTH = 12;           // operand / sum width
  localparam int LOW   = 6;            // stage-1 low slice width
  localparam int HIGH  = WIDTH - LOW;  // stage-2 high slice width
  localparam int IDW   = 2;            // requester id width, >= clog2(NREQ)

  // Everything stage 2 needs: the untouched high operands plus the finished low half.
  typedef struct packed {
    logic [IDW-1:0]  id;
    logic [HIGH-1:0] a_hi;
    logic [HIGH-1:0] b_hi;
    logic [LOW-1:0]  lo_sum;
    logic            lo_carry;
  } s1_t;

  typedef struct packed {
    logic [IDW-1:0]   id;
    logic [WIDTH-1:0] sum;
    logic             cout;
  } resp_t;

endpackage

// File: rtl/shared_adder_sched_if.sv
// Request/response bundle between requesters, the scheduler and the consumer.
// Ports: req_valid/req_ready/req_a/req_b/req_cin (one slice per requester),
//        resp_valid/resp_ready/resp_id/resp_sum/resp_cout. master = environment, slave = scheduler.
interface shared_adder_sched_if #(
  parameter int NREQ = 2
);
  import shared_adder_sched_pkg::*;

  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic [NREQ-1:0]       req_cin;
  logic                  resp_valid;
  logic                  resp_ready;
  logic [IDW-1:0]        resp_id;
  logic [WIDTH-1:0]      resp_sum;
  logic                  resp_cout;

  modport master (
    output req_valid, req_a, req_b, req_cin, resp_ready,
    input  req_ready, resp_valid, resp_id, resp_sum, resp_cout
  );

  modport slave (
    input  req_valid, req_a, req_b, req_cin, resp_ready,
    output req_ready, resp_valid, resp_id, resp_sum, resp_cout
  );

endinterface

// File: rtl/shared_adder_sched_rr_arbiter.sv
// Combinational round-robin arbiter: first valid requester at or after i_ptr wins.
// Ports: i_req (valid vector), i_ptr (search start), i_en (grant enable),
//        o_grant (one-hot, gated by i_en), o_winner (index, ungated), o_any (some request pending).
module shared_adder_sched_rr_arbiter #(
  parameter int NREQ = 2,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IDW-1:0]  i_ptr,
  input  logic            i_en,
  output logic [NREQ-1:0] o_grant,
  output logic [IDW-1:0]  o_winner,
  output logic            o_any
);

  always_comb begin
    o_winner = '0;
    o_any    = 1'b0;
    // Outer loop walks priority order ptr, ptr+1, ...; inner loop keeps every
    // bit select on a constant index.
    for (int k = 0; k < NREQ; k++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!o_any && (i == ((int'(i_ptr) + k) % NREQ)) && i_req[i]) begin
          o_any    = 1'b1;
          o_winner = IDW'(i);
        end
      end
    end
  end

  always_comb begin
    o_grant = '0;
    for (int i = 0; i < NREQ; i++) begin
      o_grant[i] = i_en && o_any && (o_winner == IDW'(i));
    end
  end

endmodule

// File: rtl/shared_adder_sched.sv
// Shares one 2-stage 12-bit adder (split at bit LOW) among NREQ requesters, round-robin.
// Latency: request presented in cycle N -> resp_valid in cycle N+2; one op per cycle unstalled.
// Backpressure: resp_ready low freezes stage 2; stage 1 then fills and req_ready drops to zero.
// Ports: clk, rst (async, active-high), bus (slave side of shared_adder_sched_if).
module shared_adder_sched
  import shared_adder_sched_pkg::*;
#(
  parameter int NREQ = 2
) (
  input logic                  clk,
  input logic                  rst,
  shared_adder_sched_if.slave  bus
);

  logic             r_s1_vld;
  logic             r_s2_vld;
  s1_t              r_s1;
  resp_t            r_s2;
  logic [IDW-1:0]   r_rr_ptr;

  logic             w_adv1;
  logic             w_adv2;
  logic             w_any;
  logic             w_accept;
  logic [NREQ-1:0]  w_grant;
  logic [IDW-1:0]   w_winner;
  logic [IDW-1:0]   w_ptr_nxt;
  logic [WIDTH-1:0] w_a;
  logic [WIDTH-1:0] w_b;
  logic             w_cin;
  logic [LOW:0]     w_lo;
  logic [HIGH:0]    w_hi;

  // A stage may load when it is empty or its contents move on in the same cycle.
  assign w_adv2   = !r_s2_vld || bus.resp_ready;
  assign w_adv1   = !r_s1_vld || w_adv2;
  // rst gating keeps req_ready low for the whole reset assertion.
  assign w_accept = w_adv1 && w_any && !rst;

  shared_adder_sched_rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_arb (
    .i_req    (bus.req_valid),
    .i_ptr    (r_rr_ptr),
    .i_en     (w_adv1 && !rst),
    .o_grant  (w_grant),
    .o_winner (w_winner),
    .o_any    (w_any)
  );

  assign bus.req_ready = w_grant;
  assign w_ptr_nxt     = (w_winner == IDW'(NREQ - 1)) ? '0 : w_winner + 1'b1;

  // Operand mux for the winning requester.
  always_comb begin
    w_a   = '0;
    w_b   = '0;
    w_cin = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_winner == IDW'(i)) begin
        w_a   = bus.req_a[i*WIDTH +: WIDTH];
        w_b   = bus.req_b[i*WIDTH +: WIDTH];
        w_cin = bus.req_cin[i];
      end
    end
  end

  // Low slice this cycle, high slice next cycle using the registered carry.
  assign w_lo = {1'b0, w_a[LOW-1:0]} + {1'b0, w_b[LOW-1:0]} + {{LOW{1'b0}}, w_cin};
  assign w_hi = {1'b0, r_s1.a_hi} + {1'b0, r_s1.b_hi} + {{HIGH{1'b0}}, r_s1.lo_carry};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rr_ptr <= '0;
      r_s1_vld <= 1'b0;
      r_s2_vld <= 1'b0;
      r_s1     <= '0;
      r_s2     <= '0;
    end else begin
      if (w_accept) begin
        r_rr_ptr <= w_ptr_nxt;
      end
      if (w_adv1) begin
        r_s1_vld <= w_accept;
        if (w_accept) begin
          r_s1 <= '{id:       w_winner,
                    a_hi:     w_a[WIDTH-1:LOW],
                    b_hi:     w_b[WIDTH-1:LOW],
                    lo_sum:   w_lo[LOW-1:0],
                    lo_carry: w_lo[LOW]};
        end
      end
      // Stage-2 data only changes when a real op arrives, so a stalled
      // response stays bit-stable.
      if (w_adv2) begin
        r_s2_vld <= r_s1_vld;
        if (r_s1_vld) begin
          r_s2 <= '{id:   r_s1.id,
                    sum:  {w_hi[HIGH-1:0], r_s1.lo_sum},
                    cout: w_hi[HIGH]};
        end
      end
    end
  end

  assign bus.resp_valid = r_s2_vld;
  assign bus.resp_id    = r_s2.id;
  assign bus.resp_sum   = r_s2.sum;
  assign bus.resp_cout  = r_s2.cout;

endmodule
